// File: rtl/multi_ch_mppt.sv
// Time-shared perturb-and-observe MPPT for NCH converters, with a shared PWM counter.
// Optional dead-band hold is compiled in by defining MPPT_HOLD_EN.
module multi_ch_mppt #(
  parameter int NCH       = 2,
  parameter int DW        = 8,
  parameter int DUTY_W    = 8,
  parameter int STEP      = 4,
  parameter int DUTY_MIN  = 16,
  parameter int DUTY_MAX  = 240,
  parameter int DUTY_INIT = 128,
  parameter int HOLD_BAND = 4,
  localparam int CW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [CW-1:0]           s_ch,
  input  logic [DW-1:0]           s_v,
  input  logic [DW-1:0]           s_i,
  output logic [NCH*DUTY_W-1:0]   duty_o,
  output logic [NCH-1:0]          pwm_o,
  output logic                    upd_valid,
  output logic [CW-1:0]           upd_ch,
  output logic [2*DW-1:0]         power_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CMP  = 2'd2,
    UPD  = 2'd3
  } state_t;

  localparam logic [DUTY_W:0]   STEP_X = (DUTY_W+1)'(STEP);
  localparam logic [DUTY_W:0]   MAX_X  = (DUTY_W+1)'(DUTY_MAX);
  localparam logic [DUTY_W:0]   LOW_X  = (DUTY_W+1)'(DUTY_MIN + STEP);
  localparam logic [DUTY_W-1:0] DMIN   = DUTY_W'(DUTY_MIN);
  localparam logic [DUTY_W-1:0] DMAX   = DUTY_W'(DUTY_MAX);
  localparam logic [DUTY_W-1:0] DINIT  = DUTY_W'(DUTY_INIT);
  localparam logic [DUTY_W-1:0] ONE    = DUTY_W'(1);
  localparam logic [CW:0]       NCH_X  = (CW+1)'(NCH);

  state_t              state_r, state_s;
  logic [CW-1:0]       ch_r, idx_s;
  logic [DW-1:0]       v_r, i_r;
  logic [2*DW-1:0]     p_r;
  logic [DUTY_W-1:0]   nduty_r, nduty_s;
  logic                ndir_r, ndir_s;
  logic                ch_ok_s, hold_s, dir_t_s;
  logic [DUTY_W-1:0]   duty_r   [NCH];
  logic                dir_r    [NCH];
  logic                primed_r [NCH];
  logic [2*DW-1:0]     last_p_r [NCH];
  logic [DUTY_W-1:0]   cur_duty_s;
  logic                cur_dir_s, cur_primed_s;
  logic [2*DW-1:0]     cur_last_s;
  logic [DUTY_W:0]     ext_s, sum_s, sub_s;
  logic [DUTY_W-1:0]   cnt_r;

  assign s_ready      = rst || (state_r == IDLE);
  assign ch_ok_s      = ({1'b0, ch_r} < NCH_X);
  assign idx_s        = ch_ok_s ? ch_r : '0;
  assign cur_duty_s   = duty_r[idx_s];
  assign cur_dir_s    = dir_r[idx_s];
  assign cur_primed_s = primed_r[idx_s];
  assign cur_last_s   = last_p_r[idx_s];
  assign ext_s        = {1'b0, cur_duty_s};
  assign sum_s        = ext_s + STEP_X;
  assign sub_s        = ext_s - STEP_X;

`ifdef MPPT_HOLD_EN
  localparam logic [2*DW-1:0] BAND_X = (2*DW)'(HOLD_BAND);
  logic [2*DW-1:0] pdiff_s;

  // Absolute power change against the channel's last observation
  always_comb begin
    if (p_r >= cur_last_s) begin
      pdiff_s = p_r - cur_last_s;
    end else begin
      pdiff_s = cur_last_s - p_r;
    end
  end
  assign hold_s = (pdiff_s <= BAND_X);
`else
  assign hold_s = 1'b0;
`endif

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic: one sample walks IDLE->MUL->CMP->UPD->IDLE
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (s_valid) begin
          state_s = MUL;
        end else begin
          state_s = IDLE;
        end
      end
      MUL:     state_s = CMP;
      CMP:     state_s = UPD;
      UPD:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Perturb-and-observe decision; a clamped step also turns the direction around
  always_comb begin
    nduty_s = cur_duty_s;
    ndir_s  = cur_dir_s;
    dir_t_s = cur_dir_s;
    if (!cur_primed_s || hold_s) begin
      nduty_s = cur_duty_s;
      ndir_s  = cur_dir_s;
    end else begin
      if (p_r < cur_last_s) begin
        dir_t_s = ~cur_dir_s;
      end else begin
        dir_t_s = cur_dir_s;
      end
      if (dir_t_s) begin
        if (sum_s > MAX_X) begin
          nduty_s = DMAX;
          ndir_s  = 1'b0;
        end else begin
          nduty_s = sum_s[DUTY_W-1:0];
          ndir_s  = 1'b1;
        end
      end else begin
        if (ext_s < LOW_X) begin
          nduty_s = DMIN;
          ndir_s  = 1'b1;
        end else begin
          nduty_s = sub_s[DUTY_W-1:0];
          ndir_s  = 1'b0;
        end
      end
    end
  end

  // Sample capture, power product and registered decision
  always_ff @(posedge clk) begin
    if (rst) begin
      ch_r    <= '0;
      v_r     <= '0;
      i_r     <= '0;
      p_r     <= '0;
      nduty_r <= DINIT;
      ndir_r  <= 1'b1;
    end else begin
      if (state_r == IDLE && s_valid) begin
        ch_r <= s_ch;
        v_r  <= s_v;
        i_r  <= s_i;
      end else if (state_r == MUL) begin
        p_r <= {{DW{1'b0}}, v_r} * {{DW{1'b0}}, i_r};
      end else if (state_r == CMP) begin
        nduty_r <= nduty_s;
        ndir_r  <= ndir_s;
      end
    end
  end

  // Per-channel state and update report, written on the UPD->IDLE edge
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        duty_r[c]   <= DINIT;
        dir_r[c]    <= 1'b1;
        primed_r[c] <= 1'b0;
        last_p_r[c] <= '0;
      end
      upd_valid <= 1'b0;
      upd_ch    <= '0;
      power_o   <= '0;
    end else begin
      upd_valid <= 1'b0;
      if (state_r == UPD && ch_ok_s) begin
        duty_r[idx_s]   <= nduty_r;
        dir_r[idx_s]    <= ndir_r;
        primed_r[idx_s] <= 1'b1;
        last_p_r[idx_s] <= p_r;
        upd_valid       <= 1'b1;
        upd_ch          <= ch_r;
        power_o         <= p_r;
      end
    end
  end

  // Shared PWM carrier and per-channel comparators
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
      pwm_o <= '0;
    end else begin
      cnt_r <= cnt_r + ONE;
      for (int c = 0; c < NCH; c++) begin
        pwm_o[c] <= (cnt_r < duty_r[c]);
      end
    end
  end

  // Pack duty registers onto the output bus
  always_comb begin
    duty_o = '0;
    for (int c = 0; c < NCH; c++) begin
      duty_o[c*DUTY_W +: DUTY_W] = duty_r[c];
    end
  end

endmodule

// File: tb/tb_multi_ch_mppt.sv
// Directed bench for multi_ch_mppt: scoreboard of expected updates from a P&O reference model.
module tb_multi_ch_mppt;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_valid, s_ready;
  logic [0:0]  s_ch;
  logic [7:0]  s_v, s_i;
  logic [15:0] duty_o;
  logic [1:0]  pwm_o;
  logic        upd_valid;
  logic [0:0]  upd_ch;
  logic [15:0] power_o;

  logic        s_valid3, s_ready3;
  logic [1:0]  s_ch3;
  logic [7:0]  s_v3, s_i3;
  logic [23:0] duty3;
  logic [2:0]  pwm3;
  logic        upd_valid3;
  logic [1:0]  upd_ch3;
  logic [15:0] power3;

  typedef struct {
    int          cyc;
    int          ch;
    int          p;
    logic [15:0] duty;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0, n_err = 0, n_upd = 0, n_upd3 = 0, cyc = 0;
  int   m_duty[2], m_dir[2], m_primed[2], m_last[2];

  multi_ch_mppt u_dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_ch(s_ch),
    .s_v(s_v), .s_i(s_i), .duty_o(duty_o), .pwm_o(pwm_o), .upd_valid(upd_valid),
    .upd_ch(upd_ch), .power_o(power_o)
  );

  multi_ch_mppt #(.NCH(3)) u_dut3 (
    .clk(clk), .rst(rst), .s_valid(s_valid3), .s_ready(s_ready3), .s_ch(s_ch3),
    .s_v(s_v3), .s_i(s_i3), .duty_o(duty3), .pwm_o(pwm3), .upd_valid(upd_valid3),
    .upd_ch(upd_ch3), .power_o(power3)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_duty[c] = 128; m_dir[c] = 1; m_primed[c] = 0; m_last[c] = 0;
    end
  endtask

  task automatic model_step(int ch, int p);
    int nd;
    bit hold;
    if (m_primed[ch] == 0) begin
      m_primed[ch] = 1;
      m_last[ch]   = p;
    end else begin
      hold = 1'b0;
`ifdef MPPT_HOLD_EN
      hold = (((p > m_last[ch]) ? p - m_last[ch] : m_last[ch] - p) <= 4);
`endif
      if (!hold) begin
        if (p < m_last[ch]) m_dir[ch] = 1 - m_dir[ch];
        nd = (m_dir[ch] == 1) ? m_duty[ch] + 4 : m_duty[ch] - 4;
        if (nd > 240) begin
          nd = 240; m_dir[ch] = 1 - m_dir[ch];
        end else if (nd < 16) begin
          nd = 16; m_dir[ch] = 1 - m_dir[ch];
        end
        m_duty[ch] = nd;
      end
      m_last[ch] = p;
    end
  endtask

  task automatic push_expect(int ch, int p);
    exp_t e;
    model_step(ch, p);
    e.cyc  = cyc + 4;
    e.ch   = ch;
    e.p    = p;
    e.duty = {8'(m_duty[1]), 8'(m_duty[0])};
    sb_q.push_back(e);
  endtask

  // Scoreboard: every update pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    exp_t e;
    if (upd_valid === 1'b1) begin
      n_upd++;
      if (sb_q.size() == 0) begin
        check("unexpected_upd", 64'd1, 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("upd_cycle", 64'(cyc), 64'(e.cyc));
        check("upd_ch", 64'(upd_ch), 64'(e.ch));
        check("power_o", 64'(power_o), 64'(e.p));
        check("duty_o", 64'(duty_o), 64'(e.duty));
      end
    end
    if (upd_valid3 === 1'b1) n_upd3++;
  end

  task automatic send(int ch, int v, int i);
    bit ok = 1'b0;
    @(negedge clk);
    s_valid = 1'b1; s_ch = ch[0:0]; s_v = v[7:0]; s_i = i[7:0];
    for (int k = 0; k < 8; k++) begin
      if (s_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("send_ready", 64'(ok), 64'd1);
    if (ok) push_expect(ch, v * i);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send3(int ch, int v, int i);
    bit ok = 1'b0;
    @(negedge clk);
    s_valid3 = 1'b1; s_ch3 = ch[1:0]; s_v3 = v[7:0]; s_i3 = i[7:0];
    for (int k = 0; k < 8; k++) begin
      if (s_ready3 === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("send3_ready", 64'(ok), 64'd1);
    @(negedge clk);
    s_valid3 = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n0, n1, acc, up0, up3;
    model_reset();
    rst = 1'b1;
    s_valid = 1'b1; s_ch = 1'b0; s_v = 8'd10; s_i = 8'd10;
    s_valid3 = 1'b0; s_ch3 = 2'd0; s_v3 = 8'd0; s_i3 = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_s_ready", 64'(s_ready), 64'd1);
    check("rst_upd_valid", 64'(upd_valid), 64'd0);
    check("rst_upd_ch", 64'(upd_ch), 64'd0);
    check("rst_power", 64'(power_o), 64'd0);
    check("rst_pwm", 64'(pwm_o), 64'd0);
    check("rst_duty", 64'(duty_o), 64'h8080);
    s_valid = 1'b0;
    rst = 1'b0;

    // PWM duty 128/256 on both channels
    n0 = 0; n1 = 0;
    repeat (256) begin
      @(negedge clk);
      if (pwm_o[0] === 1'b1) n0++;
      if (pwm_o[1] === 1'b1) n1++;
    end
    check("pwm0_high", 64'(n0), 64'd128);
    check("pwm1_high", 64'(n1), 64'd128);

    // Channel 0 prime / up / down
    send(0, 10, 10);
    send(0, 11, 10);
    send(0, 10, 10);
    drain();
    check("ch0_seq_duty", 64'(duty_o[7:0]), 64'd128);

    // Channel 1 driven into the upper clamp
    for (int k = 0; k < 30; k++) send(1, k + 1, 10);
    drain();
    check("ch1_sat", 64'(duty_o[15:8]), 64'd240);
    check("ch0_indep_a", 64'(duty_o[7:0]), 64'd128);
    send(1, 1, 1);
    drain();
    check("ch1_sat_lower", 64'(duty_o[15:8]), 64'd240);
    send(1, 2, 1);
    drain();
    check("ch1_after_clamp", 64'(duty_o[15:8]), 64'd236);
    check("ch0_indep_b", 64'(duty_o[7:0]), 64'd128);

    // Backpressure: s_valid held for 12 cycles
    up0 = n_upd; acc = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge clk);
      s_valid = 1'b1; s_ch = 1'b0; s_v = 8'(20 + t); s_i = 8'd5;
      check("bp_ready", 64'(s_ready), 64'((t % 4) == 0));
      if (s_ready === 1'b1) begin
        acc++;
        push_expect(0, (20 + t) * 5);
      end
    end
    @(negedge clk);
    s_valid = 1'b0;
    drain();
    check("bp_accepts", 64'(acc), 64'd3);
    check("bp_upds", 64'(n_upd - up0), 64'd3);

    // Reset during CMP aborts the update
    up0 = n_upd;
    send(0, 50, 2);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    model_reset();
    drain();
    check("midrst_no_upd", 64'(n_upd - up0), 64'd0);
    check("midrst_duty", 64'(duty_o), 64'h8080);

    // Dead-band behaviour (held when MPPT_HOLD_EN is defined)
    send(0, 10, 10);
    send(0, 103, 1);
    drain();
`ifdef MPPT_HOLD_EN
    check("band_103", 64'(duty_o[7:0]), 64'd128);
`else
    check("band_103", 64'(duty_o[7:0]), 64'd132);
`endif
    send(0, 108, 1);
    drain();
`ifdef MPPT_HOLD_EN
    check("band_108", 64'(duty_o[7:0]), 64'd132);
`else
    check("band_108", 64'(duty_o[7:0]), 64'd136);
`endif

    // Out-of-range channel on a three-channel instance
    up3 = n_upd3;
    send3(2, 10, 10);
    send3(2, 11, 10);
    drain();
    check("dut3_ch2", 64'(duty3[23:16]), 64'd132);
    check("dut3_upds", 64'(n_upd3 - up3), 64'd2);
    send3(3, 200, 200);
    check("dut3_busy", 64'(s_ready3), 64'd0);
    drain();
    check("dut3_bad_no_upd", 64'(n_upd3 - up3), 64'd2);
    check("dut3_bad_duty", 64'(duty3), 64'h848080);

    check("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
